// File: rtl/hp1349a_pkg.sv
// Shared constants and types for the HP1349A vector display pipeline.
package hp1349a_pkg;

    localparam int unsigned H_RES_DEF = 640;
    localparam int unsigned V_RES_DEF = 480;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned ERR_W     = COORD_W + 2;

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StPlot,
        StDone
    } raster_state_e;

endpackage

// File: rtl/hp1349a_line_raster.sv
// Integer Bresenham line rasteriser: one vector per draw_enable/draw_busy handshake,
// one pixel per cycle to the framebuffer write port, with clipping and backpressure.
module hp1349a_line_raster
    import hp1349a_pkg::*;
#(
    parameter int unsigned H_RES = H_RES_DEF,
    parameter int unsigned V_RES = V_RES_DEF,
    parameter int unsigned CW    = COORD_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] i_draw_x_from,
    input  logic [CW-1:0] i_draw_y_from,
    input  logic [CW-1:0] i_draw_x_to,
    input  logic [CW-1:0] i_draw_y_to,
    input  logic          i_draw_enable,
    output logic          o_draw_busy,
    output logic [CW-1:0] o_pix_x,
    output logic [CW-1:0] o_pix_y,
    output logic          o_pix_we,
    input  logic          i_pix_ready
);

    localparam int unsigned EW = CW + 2;
    localparam logic [CW:0]          H_LIM = (CW + 1)'(H_RES);
    localparam logic [CW:0]          V_LIM = (CW + 1)'(V_RES);
    localparam logic [CW-1:0]        C_ONE = CW'(1);
    localparam logic signed [EW-1:0] E_ZERO = '0;

    raster_state_e r_state, w_state_d;
    logic [CW-1:0] r_x, r_y, r_x1, r_y1;
    logic [CW-1:0] w_x_d, w_y_d, w_x1_d, w_y1_d;
    logic signed [EW-1:0] r_dx, r_dy, r_err;
    logic signed [EW-1:0] w_dx_d, w_dy_d, w_err_d;
    logic r_sx_neg, r_sy_neg, w_sx_neg_d, w_sy_neg_d;
    logic r_busy, w_busy_d;

    logic signed [EW-1:0] w_dx_raw, w_dy_raw, w_dx_abs, w_dy_abs;
    logic signed [EW:0]   w_e2;
    logic w_in_range, w_advance, w_at_end, w_step_x, w_step_y;

    // During SETUP r_x/r_y still hold the latched start point.
    assign w_dx_raw = $signed({2'b00, r_x1}) - $signed({2'b00, r_x});
    assign w_dy_raw = $signed({2'b00, r_y1}) - $signed({2'b00, r_y});
    assign w_dx_abs = (w_dx_raw < E_ZERO) ? -w_dx_raw : w_dx_raw;
    assign w_dy_abs = (w_dy_raw < E_ZERO) ? -w_dy_raw : w_dy_raw;

    assign w_e2       = {r_err, 1'b0};
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_in_range = ({1'b0, r_x} < H_LIM) && ({1'b0, r_y} < V_LIM);
    assign w_advance  = !w_in_range || i_pix_ready;
    assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);

    assign o_pix_x     = r_x;
    assign o_pix_y     = r_y;
    assign o_draw_busy = r_busy;

    always_comb begin
        w_state_d  = r_state;
        w_x_d      = r_x;
        w_y_d      = r_y;
        w_x1_d     = r_x1;
        w_y1_d     = r_y1;
        w_dx_d     = r_dx;
        w_dy_d     = r_dy;
        w_err_d    = r_err;
        w_sx_neg_d = r_sx_neg;
        w_sy_neg_d = r_sy_neg;
        w_busy_d   = r_busy;
        o_pix_we   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (i_draw_enable) begin
                    w_x_d     = i_draw_x_from;
                    w_y_d     = i_draw_y_from;
                    w_x1_d    = i_draw_x_to;
                    w_y1_d    = i_draw_y_to;
                    w_busy_d  = 1'b1;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                w_dx_d     = w_dx_abs;
                w_dy_d     = -w_dy_abs;
                w_err_d    = w_dx_abs - w_dy_abs;
                w_sx_neg_d = !(w_dx_raw > E_ZERO);
                w_sy_neg_d = !(w_dy_raw > E_ZERO);
                w_state_d  = StPlot;
            end
            StPlot: begin
                o_pix_we = w_in_range;
                if (w_advance) begin
                    if (w_at_end) begin
                        w_state_d = StDone;
                    end else begin
                        w_err_d = r_err + (w_step_x ? r_dy : E_ZERO) + (w_step_y ? r_dx : E_ZERO);
                        if (w_step_x) w_x_d = r_sx_neg ? r_x - C_ONE : r_x + C_ONE;
                        if (w_step_y) w_y_d = r_sy_neg ? r_y - C_ONE : r_y + C_ONE;
                    end
                end
            end
            StDone: begin
                // Wait for enable to drop so a held request is not re-accepted.
                if (!i_draw_enable) begin
                    w_busy_d  = 1'b0;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= StIdle;
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_d;
            r_x      <= w_x_d;
            r_y      <= w_y_d;
            r_x1     <= w_x1_d;
            r_y1     <= w_y1_d;
            r_dx     <= w_dx_d;
            r_dy     <= w_dy_d;
            r_err    <= w_err_d;
            r_sx_neg <= w_sx_neg_d;
            r_sy_neg <= w_sy_neg_d;
            r_busy   <= w_busy_d;
        end
    end

endmodule

// File: tb/tb_hp1349a_line_raster.sv
// Bench for hp1349a_line_raster: directed cases plus random lines against a Bresenham model.
module tb_hp1349a_line_raster;

    localparam int HR = 640;
    localparam int VR = 480;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] dxf, dyf, dxt, dyt;
    logic       en, busy, we, rdy;
    logic [9:0] px, py;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    int exp_x[$], exp_y[$];
    int mdl_x[$], mdl_y[$];
    bit rnd_rdy = 1'b0;

    always #5 clk = ~clk;

    hp1349a_line_raster dut (
        .clk           (clk),
        .rst           (rst),
        .i_draw_x_from (dxf),
        .i_draw_y_from (dyf),
        .i_draw_x_to   (dxt),
        .i_draw_y_to   (dyt),
        .i_draw_enable (en),
        .o_draw_busy   (busy),
        .o_pix_x       (px),
        .o_pix_y       (py),
        .o_pix_we      (we),
        .i_pix_ready   (rdy)
    );

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: every point the line visits, endpoints inclusive, in drawing order.
    task automatic model_line(input int x0, input int y0, input int x1, input int y1);
        int x, y, dx, dy, sx, sy, err, e2;
        x  = x0;
        y  = y0;
        dx = (x1 > x0) ? x1 - x0 : x0 - x1;
        dy = (y1 > y0) ? y0 - y1 : y1 - y0;
        sx = (x0 < x1) ? 1 : -1;
        sy = (y0 < y1) ? 1 : -1;
        err = dx + dy;
        mdl_x.delete();
        mdl_y.delete();
        for (int k = 0; k < 4096; k++) begin
            mdl_x.push_back(x);
            mdl_y.push_back(y);
            if (x == x1 && y == y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic load_exp(input int x0, input int y0, input int x1, input int y1);
        model_line(x0, y0, x1, y1);
        foreach (mdl_x[i]) begin
            if (mdl_x[i] < HR && mdl_y[i] < VR) begin
                exp_x.push_back(mdl_x[i]);
                exp_y.push_back(mdl_y[i]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) rdy = ($urandom_range(0, 3) != 0);
    endtask

    task automatic garbage();
        dxf = 10'($urandom);
        dyf = 10'($urandom);
        dxt = 10'($urandom);
        dyt = 10'($urandom);
    endtask

    task automatic request(input int x0, input int y0, input int x1, input int y1);
        dxf = x0[9:0];
        dyf = y0[9:0];
        dxt = x1[9:0];
        dyt = y1[9:0];
        en  = 1'b1;
    endtask

    task automatic release_and_wait(output int d);
        en = 1'b0;
        garbage();
        d = 0;
        while (busy && d < 5000) begin
            tick();
            d++;
        end
        check("busy_release", busy, 0);
        check("writes_outstanding", exp_x.size(), 0);
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int hold, output int d);
        int k;
        load_exp(x0, y0, x1, y1);
        request(x0, y0, x1, y1);
        k = 0;
        while (!busy && k < 8) begin
            tick();
            k++;
        end
        check("accept", busy, 1);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("busy_hold", busy, 1);
        end
        release_and_wait(d);
    endtask

    function automatic int near(input int c);
        int v;
        v = c + int'($urandom_range(0, 120)) - 60;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    // Compare process: every transfer against the expected queue, every stall for stability.
    initial begin
        bit prev_stall;
        int prev_x, prev_y, ex, ey;
        prev_stall = 1'b0;
        prev_x = 0;
        prev_y = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_hold_x", px, prev_x);
                    check("stall_hold_y", py, prev_y);
                    check("stall_hold_we", we, 1);
                end
                if (we && rdy) begin
                    n_writes++;
                    if (exp_x.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_write: got (%0d,%0d), required none", px, py);
                    end else begin
                        ex = exp_x.pop_front();
                        ey = exp_y.pop_front();
                        check("pix_x", px, ex);
                        check("pix_y", py, ey);
                    end
                end
                prev_stall = we && !rdy;
                prev_x = px;
                prev_y = py;
            end
        end
    end

    initial begin
        int d, w0, x0, y0, x1, y1;
        int lit_sx[4] = '{0, 0, 1, 1};
        int lit_sy[4] = '{0, 1, 2, 3};
        int lit_r[4]  = '{3, 2, 1, 0};

        rst = 1'b1;
        en  = 1'b0;
        rdy = 1'b0;
        garbage();
        #1;
        check("reset_busy", busy, 0);
        check("reset_we", we, 0);
        check("reset_x", px, 0);
        check("reset_y", py, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        // Horizontal line, exact timeline.
        load_exp(0, 0, 3, 0);
        check("model_h_len", mdl_x.size(), 4);
        rdy = 1'b1;
        request(0, 0, 3, 0);
        tick();
        check("h_busy_after_accept", busy, 1);
        check("h_we_setup", we, 0);
        tick();
        check("h_first_we", we, 1);
        check("h_first_x", px, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("h_we_run", we, 1);
            check("h_x_run", px, i);
        end
        tick();
        check("h_we_done", we, 0);
        check("h_busy_done", busy, 1);
        release_and_wait(d);
        check("h_busy_drop_cycles", d, 1);

        // Steep and reverse diagonal, model pinned to hand-worked points.
        model_line(0, 0, 1, 3);
        check("model_steep_len", mdl_x.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("model_steep_x", mdl_x[i], lit_sx[i]);
            check("model_steep_y", mdl_y[i], lit_sy[i]);
        end
        run_line(0, 0, 1, 3, 0, d);
        check("steep_cycles", d, 6);
        model_line(3, 3, 0, 0);
        for (int i = 0; i < 4; i++) begin
            check("model_rev_x", mdl_x[i], lit_r[i]);
            check("model_rev_y", mdl_y[i], lit_r[i]);
        end
        run_line(3, 3, 0, 0, 0, d);
        check("rev_cycles", d, 6);

        // Single point with enable held.
        w0 = n_writes;
        run_line(5, 5, 5, 5, 10, d);
        check("pt_writes", n_writes - w0, 1);
        check("pt_busy_drop_cycles", d, 1);
        repeat (5) tick();
        check("pt_no_retrigger_writes", n_writes - w0, 1);
        check("pt_no_retrigger_busy", busy, 0);

        // Clipped final pixel still costs one cycle.
        model_line(0, 478, 0, 480);
        check("model_clip_len", mdl_x.size(), 3);
        w0 = n_writes;
        run_line(0, 478, 0, 480, 0, d);
        check("clip_writes", n_writes - w0, 2);
        check("clip_cycles", d, 5);

        // Backpressure on the second pixel.
        w0 = n_writes;
        load_exp(10, 10, 12, 10);
        request(10, 10, 12, 10);
        tick();
        tick();
        check("bp_first_x", px, 10);
        tick();
        check("bp_second_x", px, 11);
        check("bp_second_we", we, 1);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_x", px, 11);
            check("bp_hold_y", py, 10);
            check("bp_hold_we", we, 1);
        end
        rdy = 1'b1;
        tick();
        check("bp_third_x", px, 12);
        release_and_wait(d);
        check("bp_writes", n_writes - w0, 3);

        // Reset in the middle of a long line.
        load_exp(0, 0, 100, 0);
        request(0, 0, 100, 0);
        tick();
        en = 1'b0;
        garbage();
        repeat (8) tick();
        check("rst_pre_we", we, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_async_busy", busy, 0);
        check("rst_async_we", we, 0);
        check("rst_async_x", px, 0);
        exp_x.delete();
        exp_y.delete();
        tick();
        tick();
        check("rst_held_we", we, 0);
        #1 rst = 1'b0;
        tick();
        check("rst_idle_busy", busy, 0);
        w0 = n_writes;
        run_line(20, 30, 25, 32, 0, d);
        check("rst_after_writes", n_writes - w0, 6);

        // Random lines with random backpressure, mostly around the clip boundary.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                x0 = $urandom_range(0, 1023);
                y0 = $urandom_range(0, 1023);
            end else begin
                x0 = $urandom_range(590, 690);
                y0 = $urandom_range(430, 530);
            end
            x1 = near(x0);
            y1 = near(y0);
            run_line(x0, y0, x1, y1, $urandom_range(0, 3), d);
        end
        rnd_rdy = 1'b0;
        rdy = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hp1349a_line_raster.md
Name: hp1349a_line_raster

Overview:
- Downstream neighbour of the HP1349A command controller.
- Accepts one vector (screen-space endpoints, already scaled to 640x480) per draw_enable/draw_busy handshake and rasterises it with integer Bresenham, one pixel per cycle.
- Emits pixel writes to the framebuffer write port, with backpressure support.
- Text requests are handled by a separate glyph block and do not pass through here.

Parameters:
- H_RES, 640, horizontal pixel count; pixels with x >= H_RES are clipped.
- V_RES, 480, vertical pixel count; pixels with y >= V_RES are clipped.
- CW, 10, coordinate width in bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- draw_x_from  in  CW  start x; only valid while draw_enable=1 (tri-stated otherwise).
- draw_y_from  in  CW  start y; same validity rule.
- draw_x_to  in  CW  end x; same validity rule.
- draw_y_to  in  CW  end y; same validity rule.
- draw_enable  in  1  line request; level, held by controller until it sees draw_busy=1.
- draw_busy  out  1  high from the cycle after acceptance until the line is done AND draw_enable has been seen low.
- pix_x  out  CW  pixel x.
- pix_y  out  CW  pixel y.
- pix_we  out  1  pixel write valid.
- pix_ready  in  1  framebuffer accepts; a transfer occurs when pix_we && pix_ready.

Behaviour:
- Reset values: draw_busy=0, pix_we=0, pix_x=0, pix_y=0, state=IDLE, all internal registers 0.
- Reset mid-line aborts immediately; no further pixels are written.
- IDLE
  - If draw_enable=1 at a clock edge: latch x0,y0,x1,y1 (inputs are sampled only here, never while draw_enable=0), set draw_busy=1, go to SETUP.
- SETUP (1 cycle)
  - dx = |x1-x0|; dy = -|y1-y0|.
  - sx = +1 if x0<x1, else -1; sy = +1 if y0<y1, else -1.
  - err = dx+dy.
  - All arithmetic is signed, CW+2 bits. e2 = 2*err, computed in CW+3 bits so it cannot overflow.
  - Current point = (x0,y0). Go to PLOT.
  - First pix_we is therefore asserted 2 cycles after the accepting edge.
- PLOT
  - Present the current point on pix_x/pix_y.
  - pix_we=1 if x<H_RES and y<V_RES; otherwise pix_we=0 (clipped pixel, consumes one cycle, no write).
  - Advance only when the pixel is clipped, or when pix_we && pix_ready. Otherwise hold pix_x, pix_y and pix_we stable.
  - On advance:
    - If current point == (x1,y1), go to DONE.
    - Else: if e2 >= dy then err += dy, x += sx. If e2 <= dx then err += dx, y += sy. Both updates may happen in the same step; err is updated with both terms at once.
  - Throughput: 1 pixel/cycle while pix_ready=1.
- DONE
  - pix_we=0.
  - If draw_enable=0: draw_busy=0, go to IDLE. Otherwise keep draw_busy=1 and wait.
  - This prevents re-triggering on a still-asserted enable for short lines.
- A zero-length line (x0==x1, y0==y1) writes exactly one pixel.
- draw_enable going low during SETUP/PLOT does not abort the line.
- Endpoints are inclusive. Pixel count = max(|dx|,|dy|) + 1.
- Input coordinates up to 2^CW-1 are legal; out-of-range pixels are clipped as above.

Decomposition:
- Shared package hp1349a_pkg holds:
  - H_RES/V_RES defaults;
  - the coordinate width constant;
  - the error-term width (CW+2);
  - the raster state enum (IDLE, SETUP, PLOT, DONE).
- No sub-module is required; the single-step Bresenham update is a small combinational section inside the block.

Test Plan:
- Horizontal, (0,0)->(3,0), pix_ready=1:
  - pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles;
  - first pix_we 2 cycles after accept;
  - draw_busy drops the cycle after DONE once enable is low.
- Steep, (0,0)->(1,3):
  - pixels (0,0),(0,1),(1,2),(1,3) in that order;
  - reverse (3,3)->(0,0) yields (3,3),(2,2),(1,1),(0,0).
- Single point (5,5)->(5,5) with draw_enable held high 10 cycles:
  - exactly one pixel written;
  - draw_busy stays 1 until enable drops, then 0 the next cycle;
  - no second line is started.
- Clip, (0,478)->(0,480):
  - writes (0,478),(0,479) only;
  - y=480 step takes one cycle with pix_we=0;
  - line then completes normally.
- Backpressure, (10,10)->(12,10) with pix_ready low for 3 cycles on the second pixel:
  - (11,10) is held stable with pix_we=1 for 4 cycles;
  - total 3 writes, none duplicated or lost.
- Reset mid-line, assert rst during PLOT of (0,0)->(100,0):
  - draw_busy, pix_we and pix_x go 0 asynchronously;
  - after release the block is in IDLE and accepts a new line.
